uart_rx_async: RTL and testbench
================================

# uart_rx_async

Asynchronous UART receive engine for the CoreUARTapb core, the receive-side counterpart of the transmit engine. It oversamples the serial `rx` line on a 16x baud enable, validates the start bit, and assembles 7- or 8-bit data LSB first. It checks optional odd/even parity and the stop bit, then presents the byte either to a holding register (`rxrdy` handshake) or to the RX FIFO (write strobe). All logic runs on the system clock `clk`; the baud generator supplies only a one-cycle enable.

## Interface
- `RX_FIFO`, 0, 0 = holding register with `rxrdy`/overflow; 1 = byte pushed to external RX FIFO via `fifo_write_n`
- `clk`  in  1  system clock
- `aresetn`  in  1  reset, asynchronous, active-low
- `baud_16x`  in  1  one-`clk` pulse at 16x baud rate
- `rx`  in  1  serial input, asynchronous to `clk`, idle high
- `bit8`  in  1  1 = 8 data bits, 0 = 7
- `parity_en`  in  1  parity bit present
- `odd_n_even`  in  1  1 = odd parity, 0 = even
- `clear_rxrdy`  in  1  one-cycle strobe: CPU read of data register
- `clear_errors`  in  1  one-cycle strobe: clears `parity_err`, `framing_err`, `overflow`
- `fifo_full`  in  1  RX FIFO full (RX_FIFO=1 only)
- `rx_byte`  out  8  received data; bit 7 forced 0 in 7-bit mode; reset 0x00
- `rxrdy`  out  1  data valid (RX_FIFO=0); `!fifo_empty` semantics not handled here, tied 0 when RX_FIFO=1; reset 0
- `parity_err`  out  1  sticky; reset 0
- `framing_err`  out  1  sticky; reset 0
- `overflow`  out  1  sticky; reset 0
- `fifo_write_n`  out  1  active-low one-cycle FIFO write; reset 1

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1), followed by a 1-flop history for falling-edge detection.
- State machine: RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP. Sample counter `samp_cnt[3:0]` increments only on `baud_16x`; bit counter `bit_cnt[3:0]`.
- RX_IDLE: a synchronized falling edge moves to RX_START and clears `samp_cnt`. The edge is evaluated every `clk`, not only on `baud_16x`.
- RX_START: on the `baud_16x` with `samp_cnt`==7 (mid start bit), a low `rx` moves to RX_DATA with `samp_cnt`, `bit_cnt` cleared. A high `rx` is a glitch: return to RX_IDLE with no flags.
- RX_DATA: on `baud_16x` with `samp_cnt`==15, shift `rx` into bit `bit_cnt` of the shift register and XOR it into the running parity, then increment `bit_cnt`. After bit 7 (`bit8`=1) or bit 6 (`bit8`=0), move to RX_PARITY if `parity_en`, otherwise to RX_STOP.
- RX_PARITY: at `samp_cnt`==15, latch `perr_pending` = `rx` XOR running parity XOR `odd_n_even`. Move to RX_STOP.
- RX_STOP: at `samp_cnt`==15, sample the stop bit. A low stop bit sets `framing_err`. Set `parity_err` if `perr_pending`. Deliver the byte, then return to RX_IDLE immediately (mid stop bit) so a back-to-back start edge is caught.
- Delivery, RX_FIFO=0: if `rxrdy`=0, load `rx_byte` and set `rxrdy`. If `rxrdy`=1, set `overflow` and keep the old `rx_byte`.
- Delivery, RX_FIFO=1: if `fifo_full`=0, drive `rx_byte` and pulse `fifo_write_n` low for one `clk`. Otherwise set `overflow` and do not write.
- Errored bytes are still delivered; the flags accompany them.
- `clear_rxrdy` clears `rxrdy`. If it coincides with a delivery, the delivery wins: `rxrdy` stays 1 and `overflow` is not set.
- `clear_errors` clears all three flags. If it coincides with a new error, the set wins.
- Config inputs are static during a frame; changing them mid-frame gives undefined data but no lock-up.
- Reset mid-frame returns everything to RX_IDLE and reset values. A line held low through reset release produces no edge and no frame.

## Timing
- Synchronizer latency is 2 `clk`, plus 1 `clk` for edge detection.
- Sample points are 8 `baud_16x` pulses after edge detection, then every 16 pulses.
- `rxrdy`, flags, or `fifo_write_n` assert 1 `clk` after the mid-stop-bit `baud_16x` pulse.
- 8N1 frame: delivery occurs at pulse 8+16·9 = 152 after the edge. 8E1: pulse 168. 7N1: pulse 136.
- `rxrdy` clears 1 `clk` after `clear_rxrdy`.

## Structure
- Shared package `uart_pkg`: state encodings RX_IDLE..RX_STOP, constants SAMP_MID=7 and SAMP_END=15.
- One sub-module: `uart_rx_sync` (2-flop synchronizer plus falling-edge detect, output `rx_s`, `rx_fall`).

## Test plan
- 8N1, byte 0x5A at 16 `clk` per `baud_16x`: `rx_byte`=0x5A and `rxrdy`=1 at pulse 152, no flags. `clear_rxrdy` → `rxrdy`=0.
- 7-bit, odd parity, byte 0x41 with correct parity, then a second frame with the parity bit flipped: first frame `rx_byte`=0x41 with no error; second sets `parity_err`=1.
- Stop bit driven low, byte 0xFF: `framing_err`=1, `rx_byte`=0xFF. `clear_errors` → 0.
- Low glitch of 4 `baud_16x` pulses: returns to idle; `rxrdy` and all flags stay 0.
- RX_FIFO=0: two back-to-back frames 0x11, 0x22 without `clear_rxrdy`: `rx_byte`=0x11, `overflow`=1. With `clear_rxrdy` in the same `clk` as the second delivery: `rx_byte`=0x22, `rxrdy`=1, `overflow`=0.
- RX_FIFO=1, `fifo_full`=1 during delivery: no `fifo_write_n` pulse, `overflow`=1. Separately, assert `aresetn` mid-byte: all outputs return to reset values, and the next clean frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared receive-state encodings and sample-point constants
package uart_pkg;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  localparam logic [3:0] SAMP_MID = 4'd7;
  localparam logic [3:0] SAMP_END = 4'd15;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for rx plus falling-edge detect
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic aresetn,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);
  logic s1;
  logic [1:0] vld;
  logic hist;
  // history only arms after a genuinely sampled high, so a line low at reset release is no edge
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      s1   <= 1'b1;
      rx_s <= 1'b1;
      vld  <= 2'b00;
      hist <= 1'b0;
    end else begin
      s1   <= rx;
      rx_s <= s1;
      vld  <= {vld[0], 1'b1};
      hist <= vld[1] & rx_s;
    end
  assign rx_fall = hist & ~rx_s;
endmodule

// File: rtl/uart_rx_async.sv
// uart_rx_async: 16x-oversampled UART receiver delivering to a holding register or an RX FIFO
module uart_rx_async
  import uart_pkg::*;
#(
  parameter bit RX_FIFO = 1'b0
) (
  input  logic       clk,
  input  logic       aresetn,
  input  logic       baud_16x,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       clear_rxrdy,
  input  logic       clear_errors,
  input  logic       fifo_full,
  output logic [7:0] rx_byte,
  output logic       rxrdy,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow,
  output logic       fifo_write_n
);
  logic rx_s, rx_fall;
  rx_state_t state;
  logic [3:0] samp_cnt, bit_cnt;
  logic [7:0] sh;
  logic par, perr_pending;
  logic last_bit, busy;
  uart_rx_sync u_sync (
    .clk     (clk),
    .aresetn (aresetn),
    .rx      (rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );
  assign last_bit = bit_cnt == (bit8 ? 4'd7 : 4'd6);
  // a clear in the same cycle as a delivery frees the slot, so the delivery wins
  assign busy = RX_FIFO ? fifo_full : (rxrdy & ~clear_rxrdy);
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      state        <= RX_IDLE;
      samp_cnt     <= '0;
      bit_cnt      <= '0;
      sh           <= '0;
      par          <= 1'b0;
      perr_pending <= 1'b0;
      rx_byte      <= '0;
      rxrdy        <= 1'b0;
      parity_err   <= 1'b0;
      framing_err  <= 1'b0;
      overflow     <= 1'b0;
      fifo_write_n <= 1'b1;
    end else begin
      fifo_write_n <= 1'b1;
      if (clear_rxrdy) rxrdy <= 1'b0;
      if (clear_errors) {parity_err, framing_err, overflow} <= 3'b000;
      case (state)
        RX_IDLE:
          if (rx_fall) begin
            state    <= RX_START;
            samp_cnt <= '0;
          end
        RX_START:
          if (baud_16x) begin
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt == SAMP_MID) begin
              state        <= rx_s ? RX_IDLE : RX_DATA;
              samp_cnt     <= '0;
              bit_cnt      <= '0;
              par          <= 1'b0;
              perr_pending <= 1'b0;
            end
          end
        RX_DATA:
          if (baud_16x) begin
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt == SAMP_END) begin
              sh[bit_cnt[2:0]] <= rx_s;
              par              <= par ^ rx_s;
              bit_cnt          <= bit_cnt + 4'd1;
              if (last_bit) state <= parity_en ? RX_PARITY : RX_STOP;
            end
          end
        RX_PARITY:
          if (baud_16x) begin
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt == SAMP_END) begin
              perr_pending <= rx_s ^ par ^ odd_n_even;
              state        <= RX_STOP;
            end
          end
        RX_STOP:
          if (baud_16x) begin
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt == SAMP_END) begin
              state <= RX_IDLE;
              if (!rx_s) framing_err <= 1'b1;
              if (perr_pending) parity_err <= 1'b1;
              if (busy) overflow <= 1'b1;
              else begin
                rx_byte <= {bit8 & sh[7], sh[6:0]};
                if (RX_FIFO) fifo_write_n <= 1'b0;
                else rxrdy <= 1'b1;
              end
            end
          end
        default: state <= RX_IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_async.sv
// tb_uart_rx_async: directed frames into holding-register and FIFO variants, FIFO writes scoreboarded
module tb_uart_rx_async;
  logic clk = 1'b0, aresetn = 1'b0, baud_16x = 1'b0, rx = 1'b1;
  logic bit8 = 1'b1, parity_en = 1'b0, odd_n_even = 1'b0;
  logic clear_rxrdy = 1'b0, clear_errors = 1'b0, fifo_full = 1'b0;
  logic [7:0] rx_byte0, rx_byte1;
  logic rxrdy0, perr0, ferr0, ovf0, fwn0, rxrdy1, perr1, ferr1, ovf1, fwn1;
  int errors = 0, checks = 0, wr_cnt = 0, w = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_async #(.RX_FIFO(1'b0)) dut0 (
    .clk(clk), .aresetn(aresetn), .baud_16x(baud_16x), .rx(rx), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .clear_rxrdy(clear_rxrdy),
    .clear_errors(clear_errors), .fifo_full(fifo_full), .rx_byte(rx_byte0),
    .rxrdy(rxrdy0), .parity_err(perr0), .framing_err(ferr0), .overflow(ovf0),
    .fifo_write_n(fwn0)
  );
  uart_rx_async #(.RX_FIFO(1'b1)) dut1 (
    .clk(clk), .aresetn(aresetn), .baud_16x(baud_16x), .rx(rx), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .clear_rxrdy(clear_rxrdy),
    .clear_errors(clear_errors), .fifo_full(fifo_full), .rx_byte(rx_byte1),
    .rxrdy(rxrdy1), .parity_err(perr1), .framing_err(ferr1), .overflow(ovf1),
    .fifo_write_n(fwn1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic strobe(input logic rdy, input logic err);
    @(negedge clk);
    clear_rxrdy  = rdy;
    clear_errors = err;
    @(negedge clk);
    clear_rxrdy  = 1'b0;
    clear_errors = 1'b0;
  endtask

  task automatic count_pulses(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!baud_16x) @(posedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop_v, input logic push);
    logic p;
    int nb;
    nb = bit8 ? 8 : 7;
    p = ^(d & (bit8 ? 8'hFF : 8'h7F)) ^ odd_n_even ^ flip_par;
    if (push) exp_q.push_back(bit8 ? d : {1'b0, d[6:0]});
    @(negedge clk);
    rx = 1'b0;
    repeat (256) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      repeat (256) @(negedge clk);
    end
    if (parity_en) begin
      rx = p;
      repeat (256) @(negedge clk);
    end
    rx = stop_v;
    repeat (256) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    fork
      begin
        int bcnt = 0;
        forever begin
          @(negedge clk);
          bcnt = (bcnt == 15) ? 0 : bcnt + 1;
          baud_16x = (bcnt == 0);
        end
      end
      forever begin
        @(negedge clk);
        if (!fwn1) begin
          wr_cnt++;
          if (exp_q.size() == 0) check("fifo_unexpected_write", fwn1, 1);
          else check("fifo_byte", rx_byte1, exp_q.pop_front());
        end
      end
    join_none
    repeat (5) @(negedge clk);
    check("rst_byte", rx_byte0, 8'h00);
    check("rst_rxrdy", rxrdy0, 0);
    check("rst_perr", perr0, 0);
    check("rst_ferr", ferr0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_fwn", fwn1, 1);
    aresetn = 1'b1;
    repeat (64) @(negedge clk);
    // 8N1 0x5A with exact delivery pulse
    fork
      send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
      begin
        @(negedge clk);
        repeat (3) @(posedge clk);
        count_pulses(151);
        #1 check("8n1_rxrdy_p151", rxrdy0, 0);
        count_pulses(1);
        #1 check("8n1_rxrdy_p152", rxrdy0, 1);
        check("8n1_byte_p152", rx_byte0, 8'h5A);
      end
    join
    check("8n1_perr", perr0, 0);
    check("8n1_ferr", ferr0, 0);
    check("8n1_ovf", ovf0, 0);
    strobe(1'b1, 1'b0);
    check("8n1_rxrdy_cleared", rxrdy0, 0);
    // 7O1 good then bad parity
    bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b1;
    send_frame(8'h41, 1'b0, 1'b1, 1'b1);
    check("7o1_byte", rx_byte0, 8'h41);
    check("7o1_perr_ok", perr0, 0);
    strobe(1'b1, 1'b0);
    send_frame(8'h41, 1'b1, 1'b1, 1'b1);
    check("7o1_perr_bad", perr0, 1);
    check("7o1_perr_bad_fifo", perr1, 1);
    check("7o1_byte_bad", rx_byte0, 8'h41);
    strobe(1'b1, 1'b1);
    check("7o1_perr_cleared", perr0, 0);
    // framing error
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    check("ferr_set", ferr0, 1);
    check("ferr_byte", rx_byte0, 8'hFF);
    strobe(1'b1, 1'b1);
    check("ferr_cleared", ferr0, 0);
    repeat (512) @(negedge clk);
    // short low glitch
    w = wr_cnt;
    rx = 1'b0;
    repeat (64) @(negedge clk);
    rx = 1'b1;
    repeat (512) @(negedge clk);
    check("glitch_rxrdy", rxrdy0, 0);
    check("glitch_flags", {perr0, ferr0, ovf0}, 3'b000);
    check("glitch_writes", wr_cnt, w);
    // back-to-back without clear: overflow keeps first byte
    send_frame(8'h11, 1'b0, 1'b1, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1);
    check("b2b_byte", rx_byte0, 8'h11);
    check("b2b_ovf", ovf0, 1);
    check("b2b_rxrdy", rxrdy0, 1);
    strobe(1'b1, 1'b1);
    // back-to-back with clear in the delivery cycle
    send_frame(8'h11, 1'b0, 1'b1, 1'b1);
    fork
      send_frame(8'h22, 1'b0, 1'b1, 1'b1);
      begin
        @(negedge clk);
        repeat (3) @(posedge clk);
        count_pulses(151);
        repeat (15) @(posedge clk);
        #1 clear_rxrdy = 1'b1;
        @(posedge clk);
        #1 clear_rxrdy = 1'b0;
      end
    join
    check("coinc_byte", rx_byte0, 8'h22);
    check("coinc_rxrdy", rxrdy0, 1);
    check("coinc_ovf", ovf0, 0);
    // FIFO full blocks the write
    fifo_full = 1'b1;
    w = wr_cnt;
    send_frame(8'h77, 1'b0, 1'b1, 1'b0);
    check("full_ovf", ovf1, 1);
    check("full_no_write", wr_cnt, w);
    fifo_full = 1'b0;
    // reset mid-frame, line held low through release
    @(negedge clk);
    rx = 1'b0;
    repeat (600) @(negedge clk);
    aresetn = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_rxrdy", rxrdy0, 0);
    check("mid_rst_byte0", rx_byte0, 8'h00);
    check("mid_rst_ovf0", ovf0, 0);
    check("mid_rst_ovf1", ovf1, 0);
    check("mid_rst_byte1", rx_byte1, 8'h00);
    check("mid_rst_fwn", fwn1, 1);
    repeat (100) @(negedge clk);
    aresetn = 1'b1;
    w = wr_cnt;
    repeat (66) @(negedge clk);
    rx = 1'b1;
    repeat (1024) @(negedge clk);
    check("post_rst_no_frame", rxrdy0, 0);
    check("post_rst_no_write", wr_cnt, w);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1);
    check("post_rst_byte", rx_byte0, 8'hC3);
    check("post_rst_rxrdy", rxrdy0, 1);
    check("post_rst_ferr", ferr0, 0);
    repeat (32) @(negedge clk);
    check("fifo_rxrdy_tied", rxrdy1, 0);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
